// File: rtl/cache_definition.sv
// Shared cache/secondary-memory definitions: bus payloads, states and defaults.
package cache_definition;

  localparam int unsigned MEM_ADDR_W    = 20;
  localparam int unsigned MEM_DATA_W    = 32;
  localparam int unsigned MEM_READ_LAT  = 4;
  localparam int unsigned MEM_WRITE_LAT = 4;

  // Request from the cache controller; rw 0 = read, 1 = write.
  typedef struct packed {
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] data;
    logic                  rw;
    logic                  valid;
  } cache_to_mem_type;

  // Response to the cache controller.
  typedef struct packed {
    logic [MEM_DATA_W-1:0] data;
    logic                  ready;
  } mem_to_cache_type;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY     = 2'd1,
    DONE     = 2'd2,
    WAIT_LOW = 2'd3
  } sec_mem_state_t;

endpackage

// File: rtl/sec_mem_array.sv
// Single-port synchronous backing store with one-cycle read latency.
module sec_mem_array
  import cache_definition::*;
#(
  parameter int unsigned ADDR_W = MEM_ADDR_W
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [ADDR_W-1:0]     i_addr,
  input  logic [MEM_DATA_W-1:0] i_wdata,
  output logic [MEM_DATA_W-1:0] o_rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [MEM_DATA_W-1:0] r_mem [DEPTH];
  logic [MEM_DATA_W-1:0] r_rdata;

  // Write on we; read the addressed word every cycle into the output register.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
    r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/sec_mem_ctrl.sv
// Secondary-memory controller: accepts one cache request at a time, models
// programmable read/write latency and returns a one-cycle ready pulse.
module sec_mem_ctrl
  import cache_definition::*;
#(
  parameter int unsigned ADDR_W    = MEM_ADDR_W,
  parameter int unsigned READ_LAT  = MEM_READ_LAT,
  parameter int unsigned WRITE_LAT = MEM_WRITE_LAT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  cache_to_mem_type mem_req,
  output mem_to_cache_type mem_rsp
);

  localparam int unsigned MAX_LAT = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
  localparam int unsigned CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_LAT - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WRITE_LAT - 1);

  sec_mem_state_t        r_state;
  sec_mem_state_t        w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic [ADDR_W-1:0]     r_addr;
  logic [MEM_DATA_W-1:0] r_wdata;
  logic                  r_rw;
  logic                  r_ready;
  logic [MEM_DATA_W-1:0] r_data;
  logic                  w_cap;
  logic                  w_ready_nxt;
  logic                  w_data_ld;
  logic                  w_we;
  logic [ADDR_W-1:0]     w_arr_addr;
  logic [MEM_DATA_W-1:0] w_arr_rdata;

  // The array address follows the incoming request while idle, so a READ_LAT=1
  // read already has its word in flight; afterwards it follows the captured copy.
  sec_mem_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk     (clk),
    .i_we    (w_we),
    .i_addr  (w_arr_addr),
    .i_wdata (r_wdata),
    .o_rdata (w_arr_rdata)
  );

  // State, counter, captured request and registered response.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rw    <= 1'b0;
      r_ready <= 1'b0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ready <= w_ready_nxt;
      if (w_cap) begin
        r_addr  <= mem_req.addr[ADDR_W-1:0];
        r_wdata <= mem_req.data;
        r_rw    <= mem_req.rw;
      end
      if (w_data_ld) begin
        r_data <= w_arr_rdata;
      end
    end
  end

  // Next-state, counter and array control.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cap       = 1'b0;
    w_ready_nxt = 1'b0;
    w_data_ld   = 1'b0;
    w_we        = 1'b0;
    w_arr_addr  = r_addr;
    case (r_state)
      IDLE: begin
        w_arr_addr = mem_req.addr[ADDR_W-1:0];
        if (mem_req.valid) begin
          w_cap       = 1'b1;
          w_cnt_nxt   = mem_req.rw ? WR_LOAD : RD_LOAD;
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (r_cnt == '0) begin
          // Reset landing on the final busy cycle must not commit the write.
          w_we        = r_rw & rst_n;
          w_data_ld   = ~r_rw;
          w_ready_nxt = 1'b1;
          w_state_nxt = DONE;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      DONE: begin
        w_state_nxt = WAIT_LOW;
      end
      WAIT_LOW: begin
        if (!mem_req.valid) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign mem_rsp.data  = r_data;
  assign mem_rsp.ready = r_ready;

endmodule

// File: tb/tb_sec_mem_ctrl.sv
// Self-checking bench for sec_mem_ctrl: directed table, corner sequences and
// randomized traffic against a word-level memory model.
module tb_sec_mem_ctrl;
  import cache_definition::*;

  logic             clk;
  logic             rst_n;
  cache_to_mem_type req0, req1;
  mem_to_cache_type rsp0, rsp1;

  int checks = 0;
  int errors = 0;

  logic [31:0] mdl0 [logic [19:0]];
  logic [31:0] mdl1 [logic [19:0]];
  logic [31:0] last [2];

  typedef struct {
    logic        rw;
    logic [19:0] addr;
    logic [31:0] wdata;
    int          hold;
    logic [31:0] exp_data;
  } vec_t;

  vec_t tbl [6];

  sec_mem_ctrl #(.ADDR_W(20), .READ_LAT(4), .WRITE_LAT(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .mem_req(req0), .mem_rsp(rsp0)
  );

  sec_mem_ctrl #(.ADDR_W(20), .READ_LAT(1), .WRITE_LAT(7)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .mem_req(req1), .mem_rsp(rsp1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input int d, input cache_to_mem_type r);
    if (d == 0) req0 = r;
    else        req1 = r;
  endtask

  function automatic mem_to_cache_type rsp(input int d);
    return (d == 0) ? rsp0 : rsp1;
  endfunction

  function automatic int exp_lat(input int d, input logic rw);
    if (d == 0) return 4;
    return rw ? 7 : 1;
  endfunction

  function automatic logic [31:0] mdl_get(input int d, input logic [19:0] a);
    if (d == 0) return mdl0.exists(a) ? mdl0[a] : 32'hxxxxxxxx;
    return mdl1.exists(a) ? mdl1[a] : 32'hxxxxxxxx;
  endfunction

  // One request: checks latency and pulse uniqueness, updates the model,
  // returns the data seen with ready. Leaves the DUT idle.
  task automatic txn(input int d, input logic rw, input logic [19:0] a,
                     input logic [31:0] wd, input int hold, input bit junk,
                     output logic [31:0] dout);
    cache_to_mem_type r;
    mem_to_cache_type s;
    int n;
    int pulses;
    r = '{addr: a, data: wd, rw: rw, valid: 1'b1};
    drive(d, r);
    n = 0;
    s = rsp(d);
    do begin
      step();
      n++;
      s = rsp(d);
      if (junk && !s.ready) begin
        r.addr  = 20'($urandom);
        r.data  = $urandom;
        r.rw    = 1'($urandom);
        r.valid = 1'($urandom);
        drive(d, r);
      end
    end while (!s.ready && n < 40);
    chk("ready_latency", 32'(n), 32'(exp_lat(d, rw) + 1));
    dout = s.data;
    if (s.ready) begin
      if (rw) begin
        if (d == 0) mdl0[a] = wd;
        else        mdl1[a] = wd;
      end else begin
        last[d] = s.data;
      end
    end
    r = '{addr: a, data: wd, rw: rw, valid: (hold > 0)};
    drive(d, r);
    pulses = 0;
    for (int i = 0; i < hold; i++) begin
      step();
      if (rsp(d).ready) pulses++;
    end
    r.valid = 1'b0;
    drive(d, r);
    for (int i = 0; i < 2; i++) begin
      step();
      if (rsp(d).ready) pulses++;
    end
    chk("single_pulse", 32'(pulses), 32'd0);
  endtask

  initial begin
    cache_to_mem_type r;
    logic [31:0] dout;
    logic [31:0] expv;
    logic [19:0] pool [6];
    int pulses;

    tbl[0] = '{1'b1, 20'h00010, 32'hDEADBEEF, 0, 32'h00000000};
    tbl[1] = '{1'b0, 20'h00010, 32'h0,        6, 32'hDEADBEEF};
    tbl[2] = '{1'b1, 20'hFFFFF, 32'hCAFEF00D, 0, 32'hDEADBEEF};
    tbl[3] = '{1'b0, 20'hFFFFF, 32'h0,        6, 32'hCAFEF00D};
    tbl[4] = '{1'b1, 20'h00000, 32'h00000001, 3, 32'hCAFEF00D};
    tbl[5] = '{1'b0, 20'h00000, 32'h0,        0, 32'h00000001};

    last[0] = 32'h0;
    last[1] = 32'h0;
    req0  = '0;
    req1  = '0;
    rst_n = 1'b0;
    step();
    step();
    chk("rst_ready0", 32'(rsp0.ready), 32'd0);
    chk("rst_data0",  rsp0.data,       32'h0);
    chk("rst_ready1", 32'(rsp1.ready), 32'd0);
    chk("rst_data1",  rsp1.data,       32'h0);
    rst_n = 1'b1;

    pulses = 0;
    repeat (20) begin
      step();
      if (rsp0.ready || rsp1.ready) pulses++;
    end
    chk("idle_no_ready", 32'(pulses), 32'd0);

    // Directed table on the 4/4 instance.
    foreach (tbl[i]) begin
      txn(0, tbl[i].rw, tbl[i].addr, tbl[i].wdata, tbl[i].hold, 1'b0, dout);
      chk($sformatf("tbl%0d_data", i), dout, tbl[i].exp_data);
    end

    // Read result must hold while idle.
    for (int i = 0; i < 10; i++) begin
      step();
      chk("data_hold", rsp0.data, 32'h00000001);
    end

    // Reset on the final busy cycle of a write aborts it.
    txn(0, 1'b1, 20'h00020, 32'h0BADF00D, 0, 1'b0, dout);
    r = '{addr: 20'h00020, data: 32'h12345678, rw: 1'b1, valid: 1'b1};
    drive(0, r);
    step();
    r.valid = 1'b0;
    drive(0, r);
    repeat (3) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("abort_ready_in_rst", 32'(rsp0.ready), 32'd0);
    pulses = 0;
    repeat (10) begin
      step();
      if (rsp0.ready) pulses++;
    end
    chk("abort_no_ready", 32'(pulses), 32'd0);
    chk("abort_data_clr", rsp0.data, 32'h0);
    last[0] = 32'h0;
    last[1] = 32'h0;
    txn(0, 1'b0, 20'h00020, 32'h0, 0, 1'b0, dout);
    chk("abort_no_write", dout, 32'h0BADF00D);

    // Asymmetric latency instance: alternating write/read of one address.
    for (int i = 0; i < 4; i++) begin
      expv = $urandom;
      txn(1, 1'b1, 20'h0ABCD, expv, 0, 1'b0, dout);
      chk("lat_wr_data_kept", dout, last[1]);
      txn(1, 1'b0, 20'h0ABCD, 32'h0, i % 2, 1'b0, dout);
      chk("lat_rd_data", dout, expv);
    end

    // Randomized traffic against the model, with busy-time request noise.
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 6; i++) begin
        pool[i] = 20'($urandom);
        txn(d, 1'b1, pool[i], $urandom, 0, 1'b1, dout);
      end
      for (int i = 0; i < 25; i++) begin
        logic        rw;
        logic [19:0] a;
        logic [31:0] wd;
        rw = 1'($urandom);
        a  = pool[$urandom_range(5, 0)];
        wd = $urandom;
        expv = rw ? last[d] : mdl_get(d, a);
        txn(d, rw, a, wd, int'($urandom_range(3, 0)), 1'b1, dout);
        chk(rw ? "rand_wr_data" : "rand_rd_data", dout, expv);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
